// File: rtl/seg_scan.sv
// Eight-digit seven-segment scanner: one hex nibble per digit slot, with decimal
// points and leading-zero blanking, fed from a shadow copy captured once per frame.
module seg_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD       = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg_data_i,
  input  logic [7:0]  dp_i,
  input  logic        blank_lz_i,
  input  logic        en_i,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        frame_o
);
  localparam int          CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [7:0]  OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  // XOR mask that converts the active-low working form to the output polarity
  localparam logic [7:0]  POL = ~OFF;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   sh_data;
  logic [7:0]    sh_dp;
  logic          sh_blz;

  logic          frame_start;
  logic [31:0]   cur_data;
  logic [7:0]    cur_dp;
  logic          cur_blz;
  logic [3:0]    nib;
  logic [7:0]    blank;
  logic          zero_above;
  logic          active;
  logic [7:0]    an_al;
  logic [7:0]    seg_al;

  function automatic logic [7:0] hex_al(input logic [3:0] n);
    case (n)
      4'h0: hex_al = 8'hC0;  4'h1: hex_al = 8'hF9;
      4'h2: hex_al = 8'hA4;  4'h3: hex_al = 8'hB0;
      4'h4: hex_al = 8'h99;  4'h5: hex_al = 8'h92;
      4'h6: hex_al = 8'h82;  4'h7: hex_al = 8'hF8;
      4'h8: hex_al = 8'h80;  4'h9: hex_al = 8'h90;
      4'hA: hex_al = 8'h88;  4'hB: hex_al = 8'h83;
      4'hC: hex_al = 8'hC6;  4'hD: hex_al = 8'hA1;
      4'hE: hex_al = 8'h86;  default: hex_al = 8'h8E;
    endcase
  endfunction

  assign frame_start = en_i && (cnt == '0) && (idx == 3'd0);

  // On the frame-start cycle the fresh inputs are already the frame's data.
  assign cur_data = frame_start ? seg_data_i : sh_data;
  assign cur_dp   = frame_start ? dp_i       : sh_dp;
  assign cur_blz  = frame_start ? blank_lz_i : sh_blz;

  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int k = 7; k >= 0; k--) begin
      zero_above = zero_above && (cur_data[4*k +: 4] == 4'h0);
      if (k >= 1) blank[k] = cur_blz && zero_above;
    end
  end

  assign nib    = cur_data[{idx, 2'b00} +: 4];
  assign active = (32'(cnt) >= DEAD) && !blank[idx];
  assign an_al  = ~(8'b1 << idx);

  always_comb begin
    seg_al = hex_al(nib);
    if (cur_dp[idx]) seg_al[7] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 3'd0;
      sh_data <= '0;
      sh_dp   <= '0;
      sh_blz  <= 1'b0;
      frame_o <= 1'b0;
      an_o    <= OFF;
      seg_o   <= OFF;
    end else if (!en_i) begin
      cnt     <= '0;
      idx     <= 3'd0;
      frame_o <= 1'b0;
      an_o    <= OFF;
      seg_o   <= OFF;
    end else begin
      frame_o <= frame_start;
      if (frame_start) begin
        sh_data <= seg_data_i;
        sh_dp   <= dp_i;
        sh_blz  <= blank_lz_i;
      end
      if (cnt == LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an_o  <= active ? (an_al ^ POL)  : OFF;
      seg_o <= active ? (seg_al ^ POL) : OFF;
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: per-cycle comparison against a frame/slot arithmetic model,
// plus hand-computed checkpoints along a directed scenario.
module tb_seg_scan;
  localparam int SD = 8;
  localparam int DD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg_data = 32'h12345678;
  logic [7:0]  dp = 8'h00;
  logic        blz = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  an, seg;
  logic        frame;

  seg_scan #(.SCAN_DIV(SD), .DEAD(DD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .seg_data_i(seg_data), .dp_i(dp),
    .blank_lz_i(blz), .en_i(en), .an_o(an), .seg_o(seg), .frame_o(frame)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: p counts enabled cycles since the scan (re)started; a frame is 8*SD cycles.
  int          p = 0;
  int          ph, slot;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0;
  logic        m_blz = 1'b0;
  logic [3:0]  m_nib;
  logic        m_blank;
  logic [7:0]  e_an = 8'hFF, e_seg = 8'hFF;
  logic        e_fr = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      p = 0; m_data = '0; m_dp = '0; m_blz = 1'b0;
      e_an = 8'hFF; e_seg = 8'hFF; e_fr = 1'b0;
    end else if (!en) begin
      p = 0; e_an = 8'hFF; e_seg = 8'hFF; e_fr = 1'b0;
    end else begin
      ph   = p % (8 * SD);
      slot = ph / SD;
      e_fr = (ph == 0);
      if (ph == 0) begin
        m_data = seg_data; m_dp = dp; m_blz = blz;
      end
      m_nib   = 4'((m_data >> (4 * slot)) & 32'hF);
      m_blank = m_blz && (slot >= 1) && ((m_data >> (4 * slot)) == 32'd0);
      if ((ph % SD) >= DD && !m_blank) begin
        e_an = 8'hFF;
        e_an[slot] = 1'b0;
        e_seg = hex_tab[m_nib];
        if (m_dp[slot]) e_seg[7] = 1'b0;
      end else begin
        e_an = 8'hFF; e_seg = 8'hFF;
      end
      p++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      tests++;
      if ({an, seg, frame} !== (rst ? {8'hFF, 8'hFF, 1'b0} : {e_an, e_seg, e_fr})) begin
        fails++;
        $display("FAIL model t=%0t: an=%h seg=%h frame=%b expected an=%h seg=%h frame=%b",
                 $time, an, seg, frame, e_an, e_seg, e_fr);
      end
      tests++;
      if ($countones(~an) > 1) begin
        fails++;
        $display("FAIL onehot t=%0t: an=%h expected at most one low bit", $time, an);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  int bad;

  initial begin
    cyc(3);
    chk("rst_an", an, 8'hFF); chk("rst_seg", seg, 8'hFF); chk("rst_frame", {7'd0, frame}, 8'h00);
    chk_on = 1'b1;
    rst = 1'b0;
    cyc(1); chk("first_frame", {7'd0, frame}, 8'h01);
    cyc(1); chk("dead_an", an, 8'hFF); chk("frame_once", {7'd0, frame}, 8'h00);
    cyc(1); chk("slot0_an", an, 8'hFE); chk("slot0_seg", seg, 8'h80);
    cyc(5); chk("slot0_hold", an, 8'hFE);
    cyc(1); chk("slot1_dead", an, 8'hFF);
    cyc(50); chk("slot7_an", an, 8'h7F); chk("slot7_seg", seg, 8'hF9);
    cyc(6); chk("frame_64", {7'd0, frame}, 8'h01);
    // tearing: new data lands in slot 3 of this frame
    cyc(26); seg_data = 32'hFFFFFFFF;
    cyc(32); chk("tear_an", an, 8'h7F); chk("tear_seg", seg, 8'hF9);
    cyc(6); chk("tear_frame", {7'd0, frame}, 8'h01);
    cyc(2); chk("tear_new", seg, 8'h8E);
    // leading-zero blanking
    seg_data = 32'h00000A05; blz = 1'b1;
    cyc(64); chk("lz_d0_an", an, 8'hFE); chk("lz_d0_seg", seg, 8'h92);
    cyc(8);  chk("lz_d1_an", an, 8'hFD); chk("lz_d1_seg", seg, 8'hC0);
    cyc(8);  chk("lz_d2_an", an, 8'hFB); chk("lz_d2_seg", seg, 8'h88);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      if (an[7:3] != 5'h1F) bad++;
    end
    chk("lz_hi_off", 8'(bad), 8'h00);
    seg_data = 32'h0;
    cyc(48); chk("lz0_an", an, 8'hFE); chk("lz0_seg", seg, 8'hC0);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      if (an[7:1] != 7'h7F) bad++;
    end
    chk("lz0_only_d0", 8'(bad), 8'h00);
    // decimal point
    blz = 1'b0; dp = 8'h01;
    cyc(64); chk("dp_d0_an", an, 8'hFE); chk("dp_d0_seg", seg, 8'h40);
    cyc(8);  chk("dp_d1_an", an, 8'hFD); chk("dp_d1_seg", seg, 8'hC0);
    // disable during slot 5, then re-enable
    cyc(32); en = 1'b0;
    cyc(1); chk("dis_an", an, 8'hFF); chk("dis_frame", {7'd0, frame}, 8'h00);
    cyc(3); en = 1'b1;
    cyc(1); chk("reen_frame", {7'd0, frame}, 8'h01);
    cyc(1); chk("reen_dead", an, 8'hFF);
    cyc(1); chk("reen_an", an, 8'hFE); chk("reen_seg", seg, 8'h40);
    // asynchronous reset between edges
    cyc(3); chk("pre_rst_an", an, 8'hFE);
    #2 rst = 1'b1;
    #1 chk("arst_an", an, 8'hFF); chk("arst_seg", seg, 8'hFF); chk("arst_frame", {7'd0, frame}, 8'h00);
    cyc(2); rst = 1'b0;
    cyc(20);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
